// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: sequences one flash command into the SPI serializer.
// Words are pushed in this order: opcode, address bytes MSB first,
// upstream write payload, then zero dummy words that clock in read data.
// The block owns chip select for the whole transaction and marks which
// shifted-out words carry read data.
module spi_xfer_sched #(
  parameter int SSIZE      = 1,
  parameter int CSNUM      = 8,
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W      = 16,
  parameter int CS_GAP     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_vld,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_op,
  input  logic                      cmd_has_addr,
  input  logic [8*ADDR_BYTES-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]          cmd_wr_len,
  input  logic [LEN_W-1:0]          cmd_rd_len,
  input  logic                      tx_vld,
  input  logic [7:0]                tx_data,
  output logic                      tx_ready,
  output logic                      ser_wr_vld,
  output logic [SSIZE*CSNUM-1:0]    ser_wr_data,
  input  logic                      ser_wr_ready,
  input  logic                      ser_rd_last,
  output logic                      spi_cs_n,
  output logic                      rx_word_vld,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = SSIZE * CSNUM;
  localparam int AW = 8 * ADDR_BYTES;
  localparam int CW = LEN_W + 2;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDUMMY,
    DRAIN,
    GAP
  } state_t;

  state_t            state;
  logic [7:0]        op_q;
  logic              has_addr_q;
  logic [AW-1:0]     addr_sr;
  logic [LEN_W-1:0]  wr_len_q;
  logic [LEN_W-1:0]  rd_len_q;
  logic [LEN_W-1:0]  phase_cnt;
  logic [CW-1:0]     push_cnt;
  logic [CW-1:0]     shift_cnt;
  logic [CW-1:0]     shift_nxt;
  logic [CW-1:0]     nonrd;
  logic [GW-1:0]     gap_cnt;
  logic              push;

  assign push      = ser_wr_vld && ser_wr_ready;
  assign shift_nxt = shift_cnt + CW'(ser_rd_last);
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

  // Word source mux: the payload phase is a straight pass-through of the upstream stream.
  always_comb begin
    ser_wr_vld  = 1'b0;
    ser_wr_data = '0;
    tx_ready    = 1'b0;
    case (state)
      CMD: begin
        ser_wr_vld  = 1'b1;
        ser_wr_data = W'(op_q);
      end
      ADDR: begin
        ser_wr_vld  = 1'b1;
        ser_wr_data = W'(addr_sr[AW-1 -: 8]);
      end
      WDATA: begin
        ser_wr_vld  = tx_vld;
        ser_wr_data = W'(tx_data);
        tx_ready    = ser_wr_ready;
      end
      RDUMMY: begin
        ser_wr_vld  = 1'b1;
        ser_wr_data = '0;
      end
      default: begin
      end
    endcase
  end

  // Transaction FSM with chip select, done and read-word flag registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      has_addr_q  <= 1'b0;
      addr_sr     <= '0;
      wr_len_q    <= '0;
      rd_len_q    <= '0;
      phase_cnt   <= '0;
      push_cnt    <= '0;
      shift_cnt   <= '0;
      nonrd       <= '0;
      gap_cnt     <= '0;
      spi_cs_n    <= 1'b1;
      rx_word_vld <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      rx_word_vld <= ser_rd_last && busy && (shift_cnt >= nonrd);
      if (push) push_cnt <= push_cnt + CW'(1);
      if (state != IDLE) shift_cnt <= shift_nxt;
      case (state)
        IDLE: begin
          if (cmd_vld) begin
            op_q       <= cmd_op;
            has_addr_q <= cmd_has_addr;
            addr_sr    <= cmd_addr;
            wr_len_q   <= cmd_wr_len;
            rd_len_q   <= cmd_rd_len;
            nonrd      <= CW'(1) + (cmd_has_addr ? CW'(ADDR_BYTES) : CW'(0)) + CW'(cmd_wr_len);
            push_cnt   <= '0;
            shift_cnt  <= '0;
            spi_cs_n   <= 1'b0;
            state      <= CMD;
          end
        end
        CMD: begin
          if (push) begin
            if (has_addr_q) begin
              phase_cnt <= LEN_W'(ADDR_BYTES - 1);
              state     <= ADDR;
            end else if (wr_len_q != '0) begin
              phase_cnt <= wr_len_q;
              state     <= WDATA;
            end else if (rd_len_q != '0) begin
              phase_cnt <= rd_len_q;
              state     <= RDUMMY;
            end else begin
              state <= DRAIN;
            end
          end
        end
        ADDR: begin
          if (push) begin
            addr_sr <= addr_sr << 8;
            if (phase_cnt == '0) begin
              if (wr_len_q != '0) begin
                phase_cnt <= wr_len_q;
                state     <= WDATA;
              end else if (rd_len_q != '0) begin
                phase_cnt <= rd_len_q;
                state     <= RDUMMY;
              end else begin
                state <= DRAIN;
              end
            end else begin
              phase_cnt <= phase_cnt - LEN_W'(1);
            end
          end
        end
        WDATA: begin
          if (push) begin
            if (phase_cnt == LEN_W'(1)) begin
              if (rd_len_q != '0) begin
                phase_cnt <= rd_len_q;
                state     <= RDUMMY;
              end else begin
                state <= DRAIN;
              end
            end else begin
              phase_cnt <= phase_cnt - LEN_W'(1);
            end
          end
        end
        RDUMMY: begin
          if (push) begin
            if (phase_cnt == LEN_W'(1)) state <= DRAIN;
            else phase_cnt <= phase_cnt - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (shift_nxt == push_cnt) begin
            spi_cs_n <= 1'b1;
            done     <= 1'b1;
            gap_cnt  <= GW'(CS_GAP - 1);
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: directed commands against a small serializer model.
// Expected words and read flags are queued when a command is issued and
// a monitor pops and compares them as the DUT pushes and completes words.
module tb_spi_xfer_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = '0;
  logic        cmd_has_addr = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_wr_len = '0;
  logic [15:0] cmd_rd_len = '0;
  logic        tx_vld = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        ser_wr_vld;
  logic [7:0]  ser_wr_data;
  logic        ser_wr_ready = 1'b1;
  logic        ser_rd_last = 1'b0;
  logic        spi_cs_n;
  logic        rx_word_vld;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int push_total = 0;
  int rx_total = 0;
  int done_total = 0;
  bit bp_hold = 1'b0;
  logic [7:0] exp_q[$];
  bit exp_rx[$];

  spi_xfer_sched #(
    .SSIZE(1), .CSNUM(8), .ADDR_BYTES(3), .LEN_W(16), .CS_GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr),
    .cmd_wr_len(cmd_wr_len), .cmd_rd_len(cmd_rd_len),
    .tx_vld(tx_vld), .tx_data(tx_data), .tx_ready(tx_ready),
    .ser_wr_vld(ser_wr_vld), .ser_wr_data(ser_wr_data), .ser_wr_ready(ser_wr_ready),
    .ser_rd_last(ser_rd_last), .spi_cs_n(spi_cs_n), .rx_word_vld(rx_word_vld),
    .busy(busy), .done(done)
  );

  // Free-running block clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_expect(input logic [7:0] op, input bit ha, input logic [23:0] addr,
                             input int wr, input int rd, input logic [7:0] wb [4]);
    exp_q.push_back(op);
    exp_rx.push_back(1'b0);
    if (ha) begin
      for (int i = 2; i >= 0; i--) begin
        exp_q.push_back(addr[8*i +: 8]);
        exp_rx.push_back(1'b0);
      end
    end
    for (int i = 0; i < wr; i++) begin
      exp_q.push_back(wb[i]);
      exp_rx.push_back(1'b0);
    end
    for (int i = 0; i < rd; i++) begin
      exp_q.push_back(8'h00);
      exp_rx.push_back(1'b1);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] op, input bit ha, input logic [23:0] addr,
                                input int wr, input int rd, input logic [7:0] wb [4]);
    int n;
    push_expect(op, ha, addr, wr, rd, wb);
    cmd_op       = op;
    cmd_has_addr = ha;
    cmd_addr     = addr;
    cmd_wr_len   = 16'(wr);
    cmd_rd_len   = 16'(rd);
    cmd_vld      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    check_output("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    bit cs_ok;
    cs_ok = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 2000) begin
      if (spi_cs_n !== 1'b0) cs_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check_output("done_seen", done, 1);
    check_output("cs_low_during_xfer", cs_ok, 1);
    check_output("cs_high_at_done", spi_cs_n, 1);
  endtask

  task automatic drive_tx(input logic [7:0] b [4], input int n, input int gap_at);
    int k;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        tx_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      tx_vld  = 1'b1;
      tx_data = b[i];
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!tx_ready && k < 2000);
      check_output("tx_handshake", tx_ready, 1);
      @(posedge clk);
      #1;
    end
    tx_vld = 1'b0;
  endtask

  task automatic bp_during_addr();
    int k;
    bit ok;
    k = 0;
    @(negedge clk);
    while (!(ser_wr_vld && ser_wr_ready && ser_wr_data == 8'h12) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_output("bp_found_addr", ser_wr_data, 8'h12);
    bp_hold = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(ser_wr_vld && ser_wr_data == 8'h34 && !ser_wr_ready)) ok = 1'b0;
    end
    bp_hold = 1'b0;
    check_output("bp_hold_stable_34", ok, 1);
  endtask

  // Serializer model: 4-word FIFO, 8 beats per word, pulses ser_rd_last on the final beat.
  initial begin : ser_model
    logic [7:0] fq[$];
    bit pushed;
    logic [7:0] pw;
    bit active;
    int beat;
    active = 1'b0;
    beat = 0;
    forever begin
      @(negedge clk);
      pushed = rst_n && ser_wr_vld && ser_wr_ready;
      pw = ser_wr_data;
      @(posedge clk);
      #1;
      if (pushed) fq.push_back(pw);
      if (!rst_n) begin
        fq.delete();
        active = 1'b0;
        beat = 0;
        ser_rd_last = 1'b0;
      end else begin
        ser_rd_last = 1'b0;
        if (active) begin
          beat++;
          if (beat == 8) begin
            ser_rd_last = 1'b1;
            active = 1'b0;
          end
        end else if (fq.size() > 0) begin
          void'(fq.pop_front());
          active = 1'b1;
          beat = 1;
        end
      end
      ser_wr_ready = (fq.size() < 4) && !bp_hold;
    end
  end

  // Monitor: compares every pushed word and every read-word flag against the scoreboard.
  initial begin : monitor
    bit rx_pend;
    rx_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_pend = 1'b0;
      end else begin
        if (ser_wr_vld && ser_wr_ready) begin
          push_total++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_unexpected actual=%0h expected=none", ser_wr_data);
          end else begin
            check_output("push_data", ser_wr_data, exp_q.pop_front());
          end
        end
        if (rx_pend) begin
          if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_unexpected_word actual=%0b expected=none", rx_word_vld);
          end else begin
            check_output("rx_flag", rx_word_vld, exp_rx.pop_front());
          end
        end else if (rx_word_vld) begin
          checks++;
          errors++;
          $display("[TB] FAIL rx_spurious actual=1 expected=0");
        end
        if (rx_word_vld) rx_total++;
        if (done) done_total++;
        rx_pend = ser_rd_last;
      end
    end
  end

  // Watchdog so a stuck handshake still ends the run.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin : stim
    logic [7:0] wb [4];
    int p0, r0, d0, g, k;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_cs_n", spi_cs_n, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_ser_wr_vld", ser_wr_vld, 0);
    check_output("rst_tx_ready", tx_ready, 0);
    check_output("rst_rx_word_vld", rx_word_vld, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] read status");
    wb = '{8'h00, 8'h00, 8'h00, 8'h00};
    p0 = push_total; r0 = rx_total; d0 = done_total;
    apply_stimulus(8'h05, 1'b0, 24'h0, 0, 1, wb);
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check_output("rdsr_pushes", push_total - p0, 2);
    check_output("rdsr_rx_count", rx_total - r0, 1);
    check_output("rdsr_done_count", done_total - d0, 1);
    check_output("rdsr_queue_left", exp_q.size() + exp_rx.size(), 0);

    $display("[TB] page program with tx gap and addr backpressure");
    wb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    p0 = push_total; r0 = rx_total; d0 = done_total;
    apply_stimulus(8'h02, 1'b1, 24'h123456, 4, 0, wb);
    fork
      drive_tx(wb, 4, 2);
      bp_during_addr();
      wait_done();
    join
    @(posedge clk);
    #1;
    check_output("pp_pushes", push_total - p0, 8);
    check_output("pp_rx_count", rx_total - r0, 0);
    check_output("pp_done_count", done_total - d0, 1);
    check_output("pp_queue_left", exp_q.size() + exp_rx.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] WREN then back-to-back WREN");
    wb = '{8'h00, 8'h00, 8'h00, 8'h00};
    p0 = push_total; d0 = done_total;
    apply_stimulus(8'h06, 1'b0, 24'h0, 0, 0, wb);
    wait_done();
    push_expect(8'h06, 1'b0, 24'h0, 0, 0, wb);
    cmd_op = 8'h06; cmd_has_addr = 1'b0; cmd_wr_len = '0; cmd_rd_len = '0;
    cmd_vld = 1'b1;
    g = 0;
    while (!cmd_ready && g < 20) begin
      g++;
      @(negedge clk);
    end
    check_output("wren_gap_cycles", g, 2);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    @(negedge clk);
    check_output("b2b_busy", busy, 1);
    check_output("b2b_cs_low", spi_cs_n, 0);
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check_output("wren_pushes", push_total - p0, 2);
    check_output("wren_done_count", done_total - d0, 2);

    $display("[TB] fast read");
    wb = '{8'hFF, 8'h00, 8'h00, 8'h00};
    p0 = push_total; r0 = rx_total;
    apply_stimulus(8'h0B, 1'b1, 24'h000100, 1, 3, wb);
    fork
      drive_tx(wb, 1, 99);
      wait_done();
    join
    @(posedge clk);
    #1;
    check_output("fr_pushes", push_total - p0, 8);
    check_output("fr_rx_count", rx_total - r0, 3);
    check_output("fr_queue_left", exp_q.size() + exp_rx.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset during address phase");
    wb = '{8'h00, 8'h00, 8'h00, 8'h00};
    apply_stimulus(8'h03, 1'b1, 24'hABCDEF, 0, 2, wb);
    k = 0;
    @(negedge clk);
    while (!(ser_wr_vld && ser_wr_data == 8'hCD) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_output("rst_found_addr", ser_wr_data, 8'hCD);
    d0 = done_total;
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_cs_n", spi_cs_n, 1);
    check_output("async_rst_busy", busy, 0);
    check_output("async_rst_wr_vld", ser_wr_vld, 0);
    exp_q.delete();
    exp_rx.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("no_done_on_reset", done_total - d0, 0);
    p0 = push_total; r0 = rx_total; d0 = done_total;
    apply_stimulus(8'h05, 1'b0, 24'h0, 0, 1, wb);
    wait_done();
    @(posedge clk);
    #1;
    check_output("post_rst_pushes", push_total - p0, 2);
    check_output("post_rst_rx_count", rx_total - r0, 1);
    check_output("post_rst_done_count", done_total - d0, 1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
